// File: rtl/serial_fulladd.sv
// Bit-serial adder: one full-add cell plus a registered carry, LSB first, one bit per clock.
// Define SERIAL_FULLADD_SUB_EN to add a 'sub' input that turns the unit into a subtractor.
module serial_fulladd #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_FULLADD_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sumf,
  output logic             carryf
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] sum_sh;
  logic             c;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             last_bit;
  logic             bit_s;
  logic             bit_c;
  logic [WIDTH-1:0] sum_cat;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  // Handshake: start is only looked at in IDLE or DONE; busy covers every
  // SHIFT cycle and done pulses for the single cycle after the last bit.
  assign accept   = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // The full-add cell.
  assign bit_s   = a_sh[0] ^ b_sh[0] ^ c;
  assign bit_c   = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
  assign sum_cat = {bit_s, sum_sh};

  always_comb begin
    b_load = b;
    c_load = cin;
`ifdef SERIAL_FULLADD_SUB_EN
    // a - b computed as a + ~b + 1; carry out of 1 means no borrow.
    if (sub) begin
      b_load = ~b;
      c_load = 1'b1;
    end
`endif
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept) state_next = ST_SHIFT;
      ST_SHIFT: if (last_bit) state_next = ST_DONE;
      ST_DONE:  state_next = accept ? ST_SHIFT : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == ST_SHIFT);
      done  <= (state_next == ST_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      sumf   <= '0;
      carryf <= 1'b0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b_load;
      sum_sh <= '0;
      c      <= c_load;
      cnt    <= '0;
    end else if (state == ST_SHIFT) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      sum_sh <= sum_cat[WIDTH-1:1];
      c      <= bit_c;
      cnt    <= cnt + CNT_W'(1);
      // Result registers only move on the edge that finishes the last bit.
      if (last_bit) begin
        sumf   <= sum_cat;
        carryf <= bit_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_fulladd.sv
// Directed self-checking bench for serial_fulladd (WIDTH=8), with extra
// subtract vectors when SERIAL_FULLADD_SUB_EN is defined.
module tb_serial_fulladd;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sumf;
  logic             carryf;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] last_sum;
  logic             last_carry;

  serial_fulladd #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
`ifdef SERIAL_FULLADD_SUB_EN
    .sub    (sub),
`endif
    .a      (a),
    .b      (b),
    .cin    (cin),
    .busy   (busy),
    .done   (done),
    .sumf   (sumf),
    .carryf (carryf)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation with a start pulse; optionally pokes start mid-operation.
  // Called at a negedge; returns at a negedge with the unit idle.
  task automatic run_op(input string tag, input logic [7:0] op_a, input logic [7:0] op_b,
                        input logic op_cin, input logic op_sub, input logic poke,
                        input logic [7:0] exp_sum, input logic exp_carry);
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_at = -1;
    a = op_a; b = op_b; cin = op_cin; sub = op_sub; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    cin = ~cin;
    sub = ~sub;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      if (n == 4) begin
        check({tag, " hold_sumf"}, 32'(sumf), 32'(last_sum));
        check({tag, " hold_carryf"}, 32'(carryf), 32'(last_carry));
      end
      if (poke && n == 2) begin
        start = 1'b1; a = 8'hFF; b = 8'hFF;
      end
      if (n == 3) start = 1'b0;
    end
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(WIDTH));
    check({tag, " done_at"}, 32'(done_at), 32'(WIDTH));
    check({tag, " done_count"}, 32'(done_cnt), 32'd1);
    check({tag, " sumf"}, 32'(sumf), 32'(exp_sum));
    check({tag, " carryf"}, 32'(carryf), 32'(exp_carry));
    last_sum = exp_sum;
    last_carry = exp_carry;
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;

    // Reset with start held high and random operands.
    rst = 1'b1; start = 1'b1; sub = 1'b0; cin = 1'b1;
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    last_sum = '0;
    last_carry = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset sumf", 32'(sumf), 32'h00);
    check("reset carryf", 32'(carryf), 32'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("post_reset busy", 32'(busy), 32'd0);

    // Directed vectors, hand-computed results.
    run_op("add_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0);
    run_op("add_ff_01_c", 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, 8'h01, 1'b1);
    run_op("add_aa_55_c", 8'hAA, 8'h55, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    run_op("start_busy", 8'h12, 8'h34, 1'b0, 1'b0, 1'b1, 8'h46, 1'b0);

    // Back-to-back with start held high, then reset in the fourth SHIFT cycle.
    busy_cnt = 0;
    done_cnt = 0;
    a = 8'h01; b = 8'h02; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    a = 8'h80; b = 8'h80;
    for (int n = 0; n < 31; n++) begin
      @(negedge clk);
      if (n <= 17 && busy) busy_cnt++;
      if (n <= 17 && done) done_cnt++;
      if (n == 8) begin
        check("b2b first done", 32'(done), 32'd1);
        check("b2b first sumf", 32'(sumf), 32'h03);
        check("b2b first carryf", 32'(carryf), 32'd0);
      end
      if (n == 12) check("b2b hold sumf", 32'(sumf), 32'h03);
      if (n == 17) begin
        check("b2b second done", 32'(done), 32'd1);
        check("b2b second sumf", 32'(sumf), 32'h00);
        check("b2b second carryf", 32'(carryf), 32'd1);
        check("b2b busy_cycles", 32'(busy_cnt), 32'd16);
        check("b2b done_count", 32'(done_cnt), 32'd2);
        a = 8'h33; b = 8'h44;
        done_cnt = 0;
      end
      if (n == 21) begin
        check("abort busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
      end
      if (n == 22) begin
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort sumf", 32'(sumf), 32'h00);
        check("abort carryf", 32'(carryf), 32'd0);
        rst = 1'b0; start = 1'b0;
      end
      if (n > 22 && (done || busy)) done_cnt++;
    end
    check("abort no_activity", 32'(done_cnt), 32'd0);
    last_sum = '0;
    last_carry = 1'b0;

`ifdef SERIAL_FULLADD_SUB_EN
    run_op("sub_07_05", 8'h07, 8'h05, 1'b0, 1'b1, 1'b0, 8'h02, 1'b1);
    run_op("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b1, 1'b0, 8'hFE, 1'b0);
`endif
    run_op("regress_add", 8'h0F, 8'h01, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
